// File: rtl/bsr_pkg.sv
// bsr_pkg: shared types and constants for bram_stream_reader.
package bsr_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} bsr_state_e;
  localparam int BSR_ADDR_W = 10;
  localparam int BSR_DATA_W = 36;
  localparam int BSR_CNT_W  = 11;
  localparam int MAX_WORDS  = 1024;
  localparam int PAR_LSB    = 32;
  localparam int PAR_W      = 4;
  function automatic logic [PAR_W-1:0] byte_parity(input logic [31:0] d);
    logic [PAR_W-1:0] p;
    for (int i = 0; i < PAR_W; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction
endpackage

// File: rtl/bsr_skid_fifo.sv
// bsr_skid_fifo: 2-entry synchronous FIFO; caller never pushes when full or pops when empty.
module bsr_skid_fifo #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end
  assign dout = mem[rp];
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks a BRAM address range and streams the words out over valid/ready.
// Define BSR_PARITY_CHECK_EN to add a sticky per-byte even-parity check on accepted words.
module bram_stream_reader
  import bsr_pkg::*;
#(
  parameter int ADDR_W = BSR_ADDR_W,
  parameter int DATA_W = BSR_DATA_W,
  parameter int CNT_W  = BSR_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_rd,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              parity_err
);
  bsr_state_e state, nxt;
  logic [CNT_W-1:0] total, issued, accepted, clamped;
  logic [1:0] fifo_count;
  logic [2:0] occ;
  logic rd_q, pop, accept;
  bsr_skid_fifo #(.W(DATA_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(rd_q), .pop(pop),
    .din(bram_dout), .dout(m_data), .count(fifo_count)
  );
  assign clamped = (word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_count;
  assign accept  = (state == IDLE) && start;
  assign busy    = state != IDLE;
  assign done    = state == FIN;
  assign m_valid = fifo_count != 2'd0;
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (accepted == total - CNT_W'(1));
  // Words buffered plus the one in the BRAM pipe, after this cycle's pop, must stay below 2.
  assign occ     = {1'b0, fifo_count} + {2'b0, rd_q} - {2'b0, pop};
  assign bram_rd = (state == READ) && (issued != total) && (occ < 3'd2);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (word_count == '0) ? FIN : READ;
      READ:    if (bram_rd && issued == total - CNT_W'(1)) nxt = DRAIN;
      DRAIN:   if (pop && m_last) nxt = FIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bram_addr <= '0;
      issued    <= '0;
      accepted  <= '0;
      total     <= '0;
      rd_q      <= 1'b0;
    end else begin
      state <= nxt;
      rd_q  <= bram_rd;
      if (accept) begin
        bram_addr <= start_addr;
        issued    <= '0;
        accepted  <= '0;
        total     <= clamped;
      end else begin
        if (bram_rd) begin
          bram_addr <= bram_addr + ADDR_W'(1);
          issued    <= issued + CNT_W'(1);
        end
        if (pop) accepted <= accepted + CNT_W'(1);
      end
    end
  end
`ifdef BSR_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else if (accept) parity_err <= 1'b0;
    else if (pop && byte_parity(m_data[31:0]) != m_data[PAR_LSB +: PAR_W]) parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule
